// File: rtl/aoc_types_pkg.sv
// rtl/aoc_types_pkg.sv - shared types for the dist_calc run controller
// Contents:
//   run_state_t  - run controller state encoding
//   run_status_t - debug tap bundle (pt_cnt, conn_cnt, tmo_err, cnt_err)
//   is_busy()    - true for every state except IDLE and ERROR
package aoc_types_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_WAIT_CALC,
    ST_DRAIN,
    ST_SELECT,
    ST_DONE,
    ST_ERROR
  } run_state_t;

  // Debug taps use fixed widths wide enough for any supported run size;
  // narrower counters are zero-extended into them.
  localparam int STATUS_PT_W  = 16;
  localparam int STATUS_CNT_W = 32;

  typedef struct packed {
    logic [STATUS_PT_W-1:0]  pt_cnt;
    logic [STATUS_CNT_W-1:0] conn_cnt;
    logic                    tmo_err;
    logic                    cnt_err;
  } run_status_t;

  function automatic logic is_busy(input run_state_t s);
    return !((s == ST_IDLE) || (s == ST_ERROR));
  endfunction

endpackage

// File: rtl/dist_run_ctrl_wdog_timer.sv
// rtl/dist_run_ctrl_wdog_timer.sv - watchdog counter with kick for dist_run_ctrl
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset
//   en      - count enable
//   kick    - zero the counter; wins over en
//   expired - counter has reached all-ones (holds there until kicked)
module wdog_timer #(
  parameter int TIMEOUT_W = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic kick,
  output logic expired
);

  logic [TIMEOUT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || kick) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = &cnt;

endmodule

// File: rtl/dist_run_ctrl.sv
// rtl/dist_run_ctrl.sv - run controller for the dist_calc pairwise-distance datapath
// Optional build macro: DIST_RUN_CTRL_CNT_CHECK_EN enables the connection-count check.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   start / busy             - run request / run in progress
//   src_vld / src_rdy        - upstream point handshake (gated through in LOAD)
//   calc_vld / calc_rdy      - point handshake into dist_calc
//   calc_rst_n               - dist_calc reset (low in CLEAR and after rst)
//   calc_conn_vld, calc_done - dist_calc connection strobe and completion level
//   sel_start / sel_done     - selector start pulse / completion pulse
//   done                     - one-cycle run-complete pulse
//   pt_cnt, conn_cnt         - points accepted / connections counted (saturating)
//   tmo_err, cnt_err         - sticky watchdog / count-mismatch flags
module dist_run_ctrl
  import aoc_types_pkg::*;
#(
  parameter int NUM_POINTS = 1000,
  parameter int DRAIN_CYC  = 4,
  parameter int CLR_CYC    = 2,
  parameter int TIMEOUT_W  = 24,
  parameter int EXP_CONNS  = NUM_POINTS * (NUM_POINTS - 1) / 2,
  localparam int CNT_W     = $clog2(EXP_CONNS + 1),
  localparam int PT_W      = $clog2(NUM_POINTS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  input  logic             src_vld,
  output logic             src_rdy,
  output logic             calc_vld,
  input  logic             calc_rdy,
  output logic             calc_rst_n,
  input  logic             calc_conn_vld,
  input  logic             calc_done,
  output logic             sel_start,
  input  logic             sel_done,
  output logic             done,
  output logic [PT_W-1:0]  pt_cnt,
  output logic [CNT_W-1:0] conn_cnt,
  output logic             tmo_err,
  output logic             cnt_err
);

  localparam int              PH_W       = 16;
  localparam logic [PH_W-1:0] CLR_LAST   = PH_W'(CLR_CYC - 1);
  localparam logic [PH_W-1:0] DRAIN_LAST = PH_W'(DRAIN_CYC - 1);
  localparam logic [PT_W-1:0] PT_LAST    = PT_W'(NUM_POINTS - 1);

  run_state_t      state;
  logic [PH_W-1:0] ph_cnt;
  logic            accept;
  logic            conn_en;
  logic            wd_en;
  logic            wd_kick;
  logic            wd_expired;
  logic            wd_trip;

  // The point gate is combinational so an accept never lags the handshake.
  assign calc_vld = (state == ST_LOAD) && src_vld;
  assign src_rdy  = (state == ST_LOAD) && calc_rdy;
  assign accept   = (state == ST_LOAD) && src_vld && calc_rdy;
  assign busy     = is_busy(state);
  assign conn_en  = state inside {ST_LOAD, ST_WAIT_CALC, ST_DRAIN};

  // Holding the watchdog kicked outside its counting states zeroes it on
  // every entry into a counting state.
  assign wd_en   = state inside {ST_LOAD, ST_WAIT_CALC, ST_SELECT};
  assign wd_kick = !wd_en || accept || calc_conn_vld || sel_done;
  assign wd_trip = wd_en && wd_expired && !wd_kick;

  wdog_timer #(
    .TIMEOUT_W(TIMEOUT_W)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .en     (wd_en),
    .kick   (wd_kick),
    .expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ph_cnt     <= '0;
      pt_cnt     <= '0;
      conn_cnt   <= '0;
      tmo_err    <= 1'b0;
      calc_rst_n <= 1'b0;
      sel_start  <= 1'b0;
      done       <= 1'b0;
    end else begin
      sel_start  <= 1'b0;
      done       <= 1'b0;
      calc_rst_n <= 1'b1;

      if (conn_en && calc_conn_vld && !(&conn_cnt)) begin
        conn_cnt <= conn_cnt + 1'b1;
      end

      case (state)
        ST_IDLE, ST_ERROR: begin
          if (start) begin
            state      <= ST_CLEAR;
            ph_cnt     <= '0;
            pt_cnt     <= '0;
            conn_cnt   <= '0;
            tmo_err    <= 1'b0;
            calc_rst_n <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (ph_cnt == CLR_LAST) begin
            state <= ST_LOAD;
          end else begin
            ph_cnt     <= ph_cnt + 1'b1;
            calc_rst_n <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            pt_cnt <= pt_cnt + 1'b1;
            if (pt_cnt == PT_LAST) begin
              state <= ST_WAIT_CALC;
            end
          end else if (wd_trip) begin
            state   <= ST_ERROR;
            tmo_err <= 1'b1;
          end
        end
        ST_WAIT_CALC: begin
          if (calc_done) begin
            state  <= ST_DRAIN;
            ph_cnt <= '0;
          end else if (wd_trip) begin
            state   <= ST_ERROR;
            tmo_err <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (ph_cnt == DRAIN_LAST) begin
            state     <= ST_SELECT;
            sel_start <= 1'b1;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        ST_SELECT: begin
          if (sel_done) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else if (wd_trip) begin
            state   <= ST_ERROR;
            tmo_err <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef DIST_RUN_CTRL_CNT_CHECK_EN
  // conn_cnt is frozen in SELECT, so comparing on the sel_done cycle
  // lines cnt_err up with the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_err <= 1'b0;
    end else if (start && !busy) begin
      cnt_err <= 1'b0;
    end else if ((state == ST_SELECT) && sel_done) begin
      cnt_err <= (conn_cnt != CNT_W'(EXP_CONNS));
    end
  end
`else
  assign cnt_err = 1'b0;
`endif

endmodule

// File: doc/dist_run_ctrl.md
# dist_run_ctrl

Run controller for the `dist_calc` pairwise-distance datapath. It clears the datapath and gates the upstream point stream into it until exactly `NUM_POINTS` points are accepted. It then waits for the datapath to finish and drain, and counts emitted connections. Finally it starts the downstream connection selector and reports run completion, with a watchdog timeout guarding each phase.

## Interface
Parameters:
- `NUM_POINTS`, 1000, points per run; must be ≥ 2.
- `DRAIN_CYC`, 4, cycles spent draining after `calc_done` so the `conn` pipeline can flush.
- `CLR_CYC`, 2, cycles `calc_rst_n` is held low at run start.
- `TIMEOUT_W`, 24, watchdog counter width.
- `EXP_CONNS`, `NUM_POINTS*(NUM_POINTS-1)/2`, expected connection count, used only with the check macro.

Ports (`CNT_W = $clog2(EXP_CONNS+1)`, `PT_W = $clog2(NUM_POINTS+1)`):
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  run request; honoured only in IDLE or ERROR.
- `busy`  out  1  high in every state except IDLE and ERROR.
- `src_vld`  in  1  upstream point valid.
- `src_rdy`  out  1  upstream point ready.
- `calc_vld`  out  1  drives `dist_calc.locs_vld`.
- `calc_rdy`  in  1  from `dist_calc.locs_rdy`.
- `calc_rst_n`  out  1  drives `dist_calc.rst_n`.
- `calc_conn_vld`  in  1  from `dist_calc.conn_vld`.
- `calc_done`  in  1  from `dist_calc.done`, level.
- `sel_start`  out  1  one-cycle start pulse to the selector.
- `sel_done`  in  1  selector completion pulse.
- `done`  out  1  one-cycle run-complete pulse.
- `pt_cnt`  out  PT_W  points accepted this run.
- `conn_cnt`  out  CNT_W  connections counted this run; saturating.
- `tmo_err`  out  1  sticky watchdog timeout flag.
- `cnt_err`  out  1  sticky count-mismatch flag.

## Operation
- States: IDLE, CLEAR, LOAD, WAIT_CALC, DRAIN, SELECT, DONE, ERROR.
- **IDLE / ERROR → CLEAR** on `start`:
  - Zero `pt_cnt`, `conn_cnt` and the watchdog.
  - Clear `tmo_err` and `cnt_err`.
- **CLEAR → LOAD**:
  - `calc_rst_n` is 0 for exactly `CLR_CYC` cycles, then LOAD.
  - `calc_rst_n` is also 0 whenever `rst` is high; otherwise it is 1.
- **LOAD**:
  - `calc_vld = src_vld`, `src_rdy = calc_rdy`. Both are purely combinational and forced to 0 in every other state.
  - Each `src_vld && calc_rdy` cycle increments `pt_cnt`.
  - After the `NUM_POINTS`-th acceptance, go to WAIT_CALC. The gate closes on the next cycle, so no extra point is ever accepted.
  - `calc_done` is ignored in LOAD.
- **WAIT_CALC → DRAIN** on the first cycle `calc_done` = 1, which may be the first WAIT_CALC cycle.
- **DRAIN → SELECT** after exactly `DRAIN_CYC` cycles.
- **SELECT**:
  - `sel_start` pulses on the first SELECT cycle only.
  - Wait for `sel_done`, then go to DONE.
  - A `sel_done` arriving on the same cycle as `sel_start` is accepted.
- **DONE**: `done` = 1 for one cycle, then IDLE. `start` in DONE is ignored.
- **Connection counting**: `calc_conn_vld` increments `conn_cnt` in LOAD, WAIT_CALC and DRAIN only. It saturates at all-ones.
- **Watchdog**:
  - Counts in LOAD, WAIT_CALC and SELECT.
  - Zeroed on state entry and on any progress event: an accepted point, `calc_conn_vld`, or `sel_done`.
  - Reaching all-ones sets `tmo_err` and moves to ERROR.
- **ERROR**: `busy` = 0 and all gates closed. `pt_cnt` and `conn_cnt` hold for debug. Leave only via `start` or `rst`.
- **`start` while `busy`**: ignored, with no effect on counters.

## Timing
- Reset value: state IDLE and every output 0.
- `calc_rst_n` is 0 during `rst` and returns to 1 the cycle after `rst` deasserts.
- Start-to-first-acceptance: `start` is sampled at edge T. `calc_rst_n` is low for cycles T+1 … T+CLR_CYC. LOAD begins at T+CLR_CYC+1.
- Status counters are registered and update one cycle after the counted event.
- `done` asserts exactly one cycle after the `sel_done` cycle.
- `rst` mid-run aborts immediately to IDLE with all outputs 0. The datapath is reset by the same cycle's `calc_rst_n`.

## Configuration
- `DIST_RUN_CTRL_CNT_CHECK_EN` defined:
  - On entry to DONE, compare `conn_cnt` with `EXP_CONNS`.
  - A mismatch sets `cnt_err` in the same cycle `done` is high.
  - Run completion is not blocked.
- Undefined: no comparator is built and `cnt_err` is tied to 0.

## Structure
- Add to `aoc_types_pkg`:
  - `run_state_t`, the state enum.
  - A `run_status_t` struct bundling `pt_cnt`, `conn_cnt`, `tmo_err` and `cnt_err` for debug taps.
- One sub-module, `wdog_timer`:
  - Parameter `TIMEOUT_W`.
  - Inputs `clk`, `rst`, `en`, `kick`; output `expired`.
  - `kick` has priority over counting.

## Test plan
- **Nominal run** (`NUM_POINTS=4`, `DRAIN_CYC=4`, `calc_rdy` always 1, 4 points streamed, model emits 6 `conn_vld` then `calc_done`, selector answers 3 cycles after `sel_start`) → `pt_cnt=4`, `conn_cnt=6`, one `sel_start`, `done` 1 cycle after `sel_done`, `cnt_err=0`.
- **Backpressure and overflow** (`calc_rdy` toggling, `src_vld` held high for 10 points) → exactly 4 acceptances and `src_rdy=0` from WAIT_CALC onward.
- **Timeout** (`TIMEOUT_W=4`, `calc_done` never asserted) → ERROR with `tmo_err=1` after 15 idle WAIT_CALC cycles; a following `start` clears `tmo_err` and enters CLEAR.
- **Count mismatch** (macro defined, only 5 `conn_vld`) → `cnt_err=1` during the `done` cycle; without the macro `cnt_err` stays 0.
- **Reset mid-LOAD** (`rst` after 2 points accepted) → next cycle state IDLE, `pt_cnt=0`, `calc_rst_n=0`; `src_rdy` stays 0 until a new `start`.
- **`start` while busy** (`start` pulsed in DRAIN) → no restart and counters unchanged.
